// File: rtl/arm_regfile_pkg.sv
// Shared types for the ARM banked register file.
// Mode encodings, mode_sel constants, bank and SPSR indices.
package arm_regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [2:0] SEL_CPSR = 3'd0;
  localparam logic [2:0] SEL_FIQ  = 3'd1;
  localparam logic [2:0] SEL_IRQ  = 3'd2;
  localparam logic [2:0] SEL_SVC  = 3'd3;
  localparam logic [2:0] SEL_UND  = 3'd4;
  localparam logic [2:0] SEL_ABT  = 3'd5;

  typedef enum logic [2:0] {
    BANK_USR,
    BANK_FIQ,
    BANK_IRQ,
    BANK_SVC,
    BANK_ABT,
    BANK_UND
  } bank_e;

  typedef logic [2:0] spsr_idx_t;

  localparam int NSPSR = 5;
  // 15 user r0-r14, 5 fiq r8-r12, 10 banked r13/r14
  localparam int NPHYS = 30;

endpackage

// File: rtl/regfile_bank_decode.sv
// Effective-mode decode shared by read and write paths.
// In: cpsr_mode, mode_sel, user_bank. Out: r13/r14 bank, fiq_hi, SPSR idx/valid, bad_mode.
import arm_regfile_pkg::*;

module regfile_bank_decode #(
  parameter bit FIQ_BANK = 1'b1
) (
  input  logic [4:0] cpsr_mode,
  input  logic [2:0] mode_sel,
  input  logic       user_bank,
  output bank_e      bank_hi,
  output logic       fiq_hi,
  output spsr_idx_t  spsr_idx,
  output logic       spsr_valid,
  output logic       bad_mode
);

  logic [4:0] eff;
  bank_e      mode_bank;

  always_comb begin
    eff = cpsr_mode;
    case (mode_sel)
      SEL_FIQ: eff = MODE_FIQ;
      SEL_IRQ: eff = MODE_IRQ;
      SEL_SVC: eff = MODE_SVC;
      SEL_UND: eff = MODE_UND;
      SEL_ABT: eff = MODE_ABT;
      default: eff = cpsr_mode;
    endcase
  end

  always_comb begin
    mode_bank = BANK_USR;
    bad_mode  = 1'b0;
    case (eff)
      MODE_USR: mode_bank = BANK_USR;
      MODE_SYS: mode_bank = BANK_USR;
      MODE_FIQ: mode_bank = BANK_FIQ;
      MODE_IRQ: mode_bank = BANK_IRQ;
      MODE_SVC: mode_bank = BANK_SVC;
      MODE_ABT: mode_bank = BANK_ABT;
      MODE_UND: mode_bank = BANK_UND;
      default:  bad_mode  = 1'b1;
    endcase
  end

  // SPSR ignores user_bank; register banks honour it
  assign bank_hi    = user_bank ? BANK_USR : mode_bank;
  assign fiq_hi     = FIQ_BANK && !user_bank
                    && (mode_bank == BANK_FIQ);
  assign spsr_valid = (mode_bank != BANK_USR);
  assign spsr_idx   = spsr_valid
                    ? spsr_idx_t'(mode_bank) - 3'd1
                    : 3'd0;

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM banked register file: r0-r15, fiq/mode banks, SPSRs.
// NRD registered read ports with write forwarding; one write port; PC port.
import arm_regfile_pkg::*;

module arm_banked_regfile #(
  parameter int DW       = 32,
  parameter int NRD      = 3,
  parameter bit FIQ_BANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        cpsr_mode,
  input  logic [2:0]        mode_sel,
  input  logic              user_bank,
  input  logic [4*NRD-1:0]  rd_addr,
  input  logic [NRD-1:0]    rd_load,
  output logic [DW*NRD-1:0] rd_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              pc_we,
  input  logic [DW-1:0]     pc_new,
  output logic [DW-1:0]     r15,
  input  logic              spsr_we,
  input  logic [DW-1:0]     spsr_wdata,
  output logic [DW-1:0]     spsr_rdata,
  output logic              bad_mode
);

  bank_e     bank_hi;
  logic      fiq_hi;
  spsr_idx_t spsr_idx;
  logic      spsr_valid;

  regfile_bank_decode #(.FIQ_BANK(FIQ_BANK)) u_dec (
    .cpsr_mode (cpsr_mode),
    .mode_sel  (mode_sel),
    .user_bank (user_bank),
    .bank_hi   (bank_hi),
    .fiq_hi    (fiq_hi),
    .spsr_idx  (spsr_idx),
    .spsr_valid(spsr_valid),
    .bad_mode  (bad_mode)
  );

  logic [DW-1:0] regs [NPHYS];
  logic [DW-1:0] spsr [NSPSR];
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_nxt;
  logic [4:0]    wi;
  logic          wr_gpr;

  // 0-14 user, 15-19 fiq r8-r12, 20+2*(bank-1)+(r14?1:0)
  function automatic logic [4:0] map_idx(
    input logic [3:0] a,
    input bank_e      b,
    input logic       fh
  );
    logic [4:0] idx;
    idx = {1'b0, a};
    if (a >= 4'd8 && a <= 4'd12 && fh)
      idx = {1'b0, a} + 5'd7;
    else if (a >= 4'd13 && a <= 4'd14
             && b != BANK_USR)
      idx = 5'd18 + {1'b0, b, 1'b0}
          + {4'd0, a == 4'd14};
    return idx;
  endfunction

  assign wi     = map_idx(wr_addr, bank_hi, fiq_hi);
  assign wr_gpr = wr_en && (wr_addr != 4'd15);
  assign pc_nxt = pc_we ? pc_new
                : (wr_en && wr_addr == 4'd15) ? wr_data
                : pc;

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
      for (int i = 0; i < NSPSR; i++) spsr[i] <= '0;
      pc <= '0;
    end else begin
      if (wr_gpr) regs[wi] <= wr_data;
      if (spsr_we && spsr_valid)
        spsr[spsr_idx] <= spsr_wdata;
      pc <= pc_nxt;
    end
  end

  assign r15        = pc;
  assign spsr_rdata = spsr_valid ? spsr[spsr_idx] : '0;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [3:0]    ra;
    logic [4:0]    ri;
    logic [DW-1:0] rv;
    logic [DW-1:0] q;

    assign ra = rd_addr[4*k +: 4];
    assign ri = map_idx(ra, bank_hi, fiq_hi);

    always_comb begin
      rv = regs[ri];
      if (ra == 4'd15)
        rv = pc_nxt;
      else if (wr_gpr && wi == ri)
        rv = wr_data;
    end

    always_ff @(negedge clk) begin
      if (rst)             q <= '0;
      else if (rd_load[k]) q <= rv;
    end

    assign rd_data[DW*k +: DW] = q;
  end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Bench for arm_banked_regfile: FIQ_BANK=1 and FIQ_BANK=0 instances
// on shared inputs, checked against a named-register reference model.
module tb_arm_banked_regfile;

  localparam int DW  = 32;
  localparam int NRD = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        cpsr_mode;
  logic [2:0]        mode_sel;
  logic              user_bank;
  logic [4*NRD-1:0]  rd_addr;
  logic [NRD-1:0]    rd_load;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DW-1:0]     wr_data;
  logic              pc_we;
  logic [DW-1:0]     pc_new;
  logic              spsr_we;
  logic [DW-1:0]     spsr_wdata;

  logic [DW*NRD-1:0] rd1, rd0;
  logic [DW-1:0]     r15_1, r15_0, sp1, sp0;
  logic              bad1, bad0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arm_banked_regfile #(.DW(DW), .NRD(NRD), .FIQ_BANK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cpsr_mode(cpsr_mode),
    .mode_sel(mode_sel), .user_bank(user_bank),
    .rd_addr(rd_addr), .rd_load(rd_load), .rd_data(rd1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_we(pc_we), .pc_new(pc_new), .r15(r15_1),
    .spsr_we(spsr_we), .spsr_wdata(spsr_wdata),
    .spsr_rdata(sp1), .bad_mode(bad1)
  );

  arm_banked_regfile #(.DW(DW), .NRD(NRD), .FIQ_BANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cpsr_mode(cpsr_mode),
    .mode_sel(mode_sel), .user_bank(user_bank),
    .rd_addr(rd_addr), .rd_load(rd_load), .rd_data(rd0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_we(pc_we), .pc_new(pc_new), .r15(r15_0),
    .spsr_we(spsr_we), .spsr_wdata(spsr_wdata),
    .spsr_rdata(sp0), .bad_mode(bad0)
  );

  // Reference model: registers named by owner mode and number
  logic [DW-1:0] m1 [string];
  logic [DW-1:0] m0 [string];
  logic [DW-1:0] spm [string];
  logic [DW-1:0] pcm;
  logic [DW-1:0] e1 [NRD];
  logic [DW-1:0] e0 [NRD];

  function automatic string mname();
    logic [4:0] m;
    case (mode_sel)
      3'd1: m = 5'b10001;
      3'd2: m = 5'b10010;
      3'd3: m = 5'b10011;
      3'd4: m = 5'b11011;
      3'd5: m = 5'b10111;
      default: m = cpsr_mode;
    endcase
    case (m)
      5'b10000: return "usr";
      5'b10001: return "fiq";
      5'b10010: return "irq";
      5'b10011: return "svc";
      5'b10111: return "abt";
      5'b11011: return "und";
      5'b11111: return "sys";
      default:  return "bad";
    endcase
  endfunction

  function automatic bit is_priv(string n);
    return n == "fiq" || n == "irq" || n == "svc"
        || n == "abt" || n == "und";
  endfunction

  function automatic string key(int a, bit fb);
    string n;
    n = mname();
    if (a >= 8 && a <= 12 && fb && n == "fiq" && !user_bank)
      return $sformatf("fiq%0d", a);
    if (a >= 13 && is_priv(n) && !user_bank)
      return $sformatf("%s%0d", n, a);
    return $sformatf("usr%0d", a);
  endfunction

  function automatic logic [DW-1:0] getv(bit fb, int a);
    string k;
    if (a == 15) return pcm;
    k = key(a, fb);
    if (fb) return m1.exists(k) ? m1[k] : '0;
    return m0.exists(k) ? m0[k] : '0;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] o, logic [DW-1:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; pc_we = 0; spsr_we = 0;
    rd_load = '0; user_bank = 0;
  endtask

  task automatic tick();
    string n;
    @(negedge clk);
    n = mname();
    if (rst) begin
      m1.delete(); m0.delete(); spm.delete(); pcm = '0;
      for (int k = 0; k < NRD; k++) begin e1[k] = '0; e0[k] = '0; end
    end else begin
      if (wr_en && wr_addr != 4'd15) begin
        m1[key(int'(wr_addr), 1'b1)] = wr_data;
        m0[key(int'(wr_addr), 1'b0)] = wr_data;
      end
      if (pc_we) pcm = pc_new;
      else if (wr_en && wr_addr == 4'd15) pcm = wr_data;
      if (spsr_we && is_priv(n)) spm[n] = spsr_wdata;
      for (int k = 0; k < NRD; k++)
        if (rd_load[k]) begin
          e1[k] = getv(1'b1, int'(rd_addr[4*k +: 4]));
          e0[k] = getv(1'b0, int'(rd_addr[4*k +: 4]));
        end
    end
    #1;
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd1_p%0d", k), rd1[DW*k +: DW], e1[k]);
      chk($sformatf("rd0_p%0d", k), rd0[DW*k +: DW], e0[k]);
    end
    chk("r15_1", r15_1, pcm);
    chk("r15_0", r15_0, pcm);
    chk("spsr1", sp1, (is_priv(n) && spm.exists(n)) ? spm[n] : '0);
    chk("spsr0", sp0, (is_priv(n) && spm.exists(n)) ? spm[n] : '0);
    chk("bad1", {31'd0, bad1}, {31'd0, n == "bad"});
    chk("bad0", {31'd0, bad0}, {31'd0, n == "bad"});
  endtask

  task automatic wr(logic [3:0] a, logic [DW-1:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d; tick();
  endtask

  task automatic ld0(logic [3:0] a);
    idle(); rd_load = 3'b001; rd_addr[3:0] = a; tick();
  endtask

  logic [4:0] lm [8];

  initial begin
    lm = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
           5'b10111, 5'b11011, 5'b11111, 5'b10100};
    idle();
    cpsr_mode = 5'b10000; mode_sel = 3'd3;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    pc_new = '0; spsr_wdata = '0;
    // reset with strobes asserted: reset must win
    rst = 1; wr_en = 1; pc_we = 1; pc_new = 32'h99;
    spsr_we = 1; spsr_wdata = 32'h5; rd_load = '1;
    tick();
    chk("reset_rd", rd1[31:0], 32'h0);
    chk("reset_r15", r15_1, 32'h0);
    chk("reset_spsr", sp1, 32'h0);

    mode_sel = 3'd3; wr(4'd13, 32'h1111);
    mode_sel = 3'd2; wr(4'd13, 32'h2222);
    mode_sel = 3'd3; ld0(4'd13); chk("svc_r13", rd1[31:0], 32'h1111);
    mode_sel = 3'd2; ld0(4'd13); chk("irq_r13", rd1[31:0], 32'h2222);
    mode_sel = 3'd0; ld0(4'd13); chk("usr_r13", rd1[31:0], 32'h0);

    mode_sel = 3'd1; wr(4'd9, 32'hAAAA);
    mode_sel = 3'd0; ld0(4'd9);
    chk("usr_r9_fb1", rd1[31:0], 32'h0);
    chk("usr_r9_fb0", rd0[31:0], 32'hAAAA);
    mode_sel = 3'd1; ld0(4'd9);
    chk("fiq_r9_fb1", rd1[31:0], 32'hAAAA);
    chk("fiq_r9_fb0", rd0[31:0], 32'hAAAA);

    idle(); wr_en = 1; wr_addr = 4'd5; wr_data = 32'h55;
    rd_load = 3'b001; rd_addr[3:0] = 4'd5; tick();
    chk("fwd_r5", rd1[31:0], 32'h55);
    idle(); wr_en = 1; wr_addr = 4'd15; wr_data = 32'h10;
    pc_we = 1; pc_new = 32'h20; tick();
    chk("pc_win", r15_1, 32'h20);

    mode_sel = 3'd3; wr(4'd14, 32'h33);
    idle(); user_bank = 1; wr_en = 1; wr_addr = 4'd14;
    wr_data = 32'h77; tick();
    mode_sel = 3'd0; ld0(4'd14); chk("usr_r14", rd1[31:0], 32'h77);
    mode_sel = 3'd3; ld0(4'd14); chk("svc_r14", rd1[31:0], 32'h33);

    mode_sel = 3'd4; idle(); spsr_we = 1; spsr_wdata = 32'hD3; tick();
    chk("und_spsr", sp1, 32'hD3);
    mode_sel = 3'd2; idle(); tick();
    chk("irq_spsr", sp1, 32'h0);
    mode_sel = 3'd0; cpsr_mode = 5'b10100;
    idle(); spsr_we = 1; spsr_wdata = 32'hFF; tick();
    chk("bad_flag", {31'd0, bad1}, 32'h1);
    chk("bad_spsr", sp1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(99) == 0);
      cpsr_mode  = ($urandom_range(9) == 0) ? 5'($urandom)
                 : lm[$urandom_range(7)];
      mode_sel   = 3'($urandom);
      user_bank  = ($urandom_range(4) == 0);
      rd_addr    = 12'($urandom);
      rd_load    = 3'($urandom);
      wr_en      = $urandom_range(1) == 1;
      wr_addr    = 4'($urandom);
      wr_data    = $urandom;
      pc_we      = ($urandom_range(3) == 0);
      pc_new     = $urandom;
      spsr_we    = ($urandom_range(2) == 0);
      spsr_wdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
